lfsr_gen: RTL

- Parametrised Galois LFSR pseudo-random word generator. It generalises the fixed 8-bit x^8+x^6+x^5+x+1 LFSR to:
  - any width and feedback polynomial;
  - multiple advances per output word;
  - a valid/ready output handshake;
  - seed load with zero-lockup guard;
  - period measurement.
- Sits between a configuration source (seed load) and PRBS consumers: scramblers, BIST pattern sources, test stimulus.

---
 rtl/lfsr_gen.sv | 100 ++++++++++
 1 files changed

// File: rtl/lfsr_gen.sv
// Parametrised Galois LFSR word generator with valid/ready output, seed load
// and period measurement. The word presented on out_data is the state register q.
module lfsr_gen #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = 8'h63,
    parameter int               STEPS = 1,
    parameter logic [WIDTH-1:0] SEED  = 8'h01,
    parameter int               CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic [CNT_W-1:0] period
);

    localparam logic [WIDTH-1:0] SEED_EFF = (SEED != '0) ? SEED : WIDTH'(1);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("lfsr_gen: WIDTH must be 2..32");
    end
    if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
        $error("lfsr_gen: STEPS must be 1..WIDTH");
    end
    if (POLY[0] != 1'b1) begin : g_bad_poly
        $error("lfsr_gen: POLY bit 0 must be set to keep the state nonzero");
    end

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] seed_r;
    logic [WIDTH-1:0] q_adv;
    logic [WIDTH-1:0] load_val;
    logic             fire;
    logic             wrap_hit;

    function automatic logic [WIDTH-1:0] nxt(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], 1'b0} ^ (v[WIDTH-1] ? POLY : '0);
    endfunction

    function automatic logic [WIDTH-1:0] adv(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] t;
        t = v;
        for (int i = 0; i < STEPS; i++) begin
            t = nxt(t);
        end
        return t;
    endfunction

    always_comb begin
        q_adv    = adv(q);
        wrap_hit = (q_adv == seed_r);
        fire     = out_valid & out_ready;
        // an all-zero seed would lock the register up, so it is replaced by 1
        load_val = (|din) ? din : WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q         <= SEED_EFF;
            seed_r    <= SEED_EFF;
            out_valid <= 1'b0;
            count     <= '0;
            period    <= '0;
            wrap      <= 1'b0;
        end else if (load) begin
            // load flushes any pending word, accepted or not
            q         <= load_val;
            seed_r    <= load_val;
            out_valid <= 1'b0;
            count     <= '0;
            period    <= '0;
            wrap      <= 1'b0;
        end else if (fire) begin
            q         <= q_adv;
            out_valid <= en;
            if (wrap_hit) begin
                wrap   <= 1'b1;
                period <= count + CNT_W'(1);
                count  <= '0;
            end else begin
                wrap   <= 1'b0;
                count  <= count + CNT_W'(1);
            end
        end else begin
            if (!out_valid && en) begin
                out_valid <= 1'b1;
            end
            wrap <= 1'b0;
        end
    end

    assign out_data = q;

endmodule
